// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared definitions for the memory-mapped I/O port: register offsets as seen
// on CPU addr[3:2], status-register bit positions and the read-data width.
// -----------------------------------------------------------------------------
package io_map_pkg;

  // Register select values (CPU addr[3:2])
  typedef enum logic [1:0] {
    IO_STATUS = 2'b00,
    IO_SWDATA = 2'b01,
    IO_RESULT = 2'b10,
    IO_RSVD   = 2'b11
  } io_reg_e;

  // Bit positions inside the STATUS register
  localparam int ST_LED_RDY = 0;
  localparam int ST_SW_RDY  = 1;

  // CPU data bus width
  localparam int IO_DATA_W = 32;

  // True when the access targets the given register
  function automatic logic reg_hit(input logic [1:0] addr, input io_reg_e which);
    return addr == which;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronises one raw asynchronous push-button into the clock domain and
// debounces it. The accepted level only changes after the synchronised input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles. A one-cycle
// press_pulse follows every accepted rising edge.
//
// After reset a button that is already held is learned as pressed without a
// pulse; the button has to be seen released before a press can pulse again.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   raw          in   raw asynchronous button input
//   level        out  debounced (accepted) button level
//   press_pulse  out  one-cycle pulse after an accepted press
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  // A single-cycle debounce still needs a one-bit counter
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [1:0]       fill;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             pulse_q;
  logic             armed;
  logic             mismatch;
  logic             accept;

  assign mismatch = (sync_b != level_q);
  assign accept   = mismatch && (cnt == CNT_MAX);

  // Two-flop synchroniser. 'fill' marks when the synchroniser holds real
  // samples again after reset, so the zeros loaded by reset are not mistaken
  // for a released button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      fill   <= 2'b00;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      fill   <= {fill[0], 1'b1};
    end
  end

  // Stability counter: any agreement between input and accepted level
  // restarts the count, so only an uninterrupted run flips the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      level_q <= sync_b;
    end else if (mismatch) begin
      cnt     <= cnt + 1'b1;
    end else begin
      cnt     <= '0;
    end
  end

  // Press pulse and re-arm logic. 'armed' stays low after reset until the
  // button has been seen released, so a button held across reset is learned
  // silently and only a fresh press produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= accept && sync_b && armed;
      if (fill[1] && !sync_b && !level_q) begin
        armed <= 1'b1;
      end
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/io_port_ctrl.sv
// -----------------------------------------------------------------------------
// io_port_ctrl
// Memory-mapped peripheral port behind the data-memory decoder (addr[7]=1).
// Debounces BTNL / BTNR, latches the switches on a BTNR press, exposes ready
// flags in STATUS and holds the CPU-written result for the 7-segment path.
//
// Register map (addr = CPU addr[3:2])
//   00 STATUS  R  {30'b0, sw_ready, led_ready}
//   01 SWDATA  R  {zero-ext, sw_data}          reading clears sw_ready
//   10 RESULT  W  calc_result <= wdata          writing clears led_ready
//              R  {zero-ext, calc_result}
//   11 reserved: reads 0, writes ignored
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   pread        in   port select, qualifies reads
//   pwrite       in   write strobe (already gated by the decoder)
//   addr         in   register select
//   wdata        in   write data
//   rdata        out  combinational read data, zero when pread=0
//   BTNL         in   raw button "result consumed / next"
//   BTNR         in   raw button "switches valid"
//   SW           in   raw switches
//   calc_result  out  registered result for the display path
// -----------------------------------------------------------------------------
module io_port_ctrl
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SW_W            = 16,
  parameter int RES_W           = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pread,
  input  logic                 pwrite,
  input  logic [1:0]           addr,
  input  logic [RES_W-1:0]     wdata,
  output logic [IO_DATA_W-1:0] rdata,
  input  logic                 BTNL,
  input  logic                 BTNR,
  input  logic [SW_W-1:0]      SW,
  output logic [RES_W-1:0]     calc_result
);

  logic            btnl_level;
  logic            btnl_pulse;
  logic            btnr_level;
  logic            btnr_pulse;
  logic            btnl_p;
  logic            btnr_p;
  logic [SW_W-1:0] sw_sync_a;
  logic [SW_W-1:0] sw_sync_b;
  logic [SW_W-1:0] sw_data;
  logic            sw_ready;
  logic            led_ready;
  logic            result_wr;
  logic            swdata_rd;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btnl (
    .clk        (clk),
    .reset      (reset),
    .raw        (BTNL),
    .level      (btnl_level),
    .press_pulse(btnl_pulse)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btnr (
    .clk        (clk),
    .reset      (reset),
    .raw        (BTNR),
    .level      (btnr_level),
    .press_pulse(btnr_pulse)
  );

  // A pulse only counts while its button is still accepted as pressed; this
  // guards against a level that has already dropped again in very short
  // debounce configurations.
  assign btnl_p = btnl_pulse && btnl_level;
  assign btnr_p = btnr_pulse && btnr_level;

  // Bus-side events. A write needs only pwrite; a clear-on-read needs a
  // genuine read (pread without pwrite).
  assign result_wr = pwrite && reg_hit(addr, IO_RESULT);
  assign swdata_rd = pread && !pwrite && reg_hit(addr, IO_SWDATA);

  // Switches are only synchronised; they are sampled on a debounced BTNR
  // press, by which time they have long settled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync_a <= '0;
      sw_sync_b <= '0;
    end else begin
      sw_sync_a <= SW;
      sw_sync_b <= sw_sync_a;
    end
  end

  // Switch capture and its ready flag. A press in the same cycle as a SWDATA
  // read wins: the flag stays set, and the read still sees the old data
  // because rdata comes from the register before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_data  <= '0;
      sw_ready <= 1'b0;
    end else if (btnr_p) begin
      sw_data  <= sw_sync_b;
      sw_ready <= 1'b1;
    end else if (swdata_rd) begin
      sw_ready <= 1'b0;
    end
  end

  // Result register and the "result consumed" flag. The RESULT write always
  // lands; only the flag clear loses against a simultaneous BTNL press.
  always_ff @(posedge clk) begin
    if (reset) begin
      calc_result <= '0;
      led_ready   <= 1'b0;
    end else begin
      if (result_wr) begin
        calc_result <= wdata;
      end
      if (btnl_p) begin
        led_ready <= 1'b1;
      end else if (result_wr) begin
        led_ready <= 1'b0;
      end
    end
  end

  // Zero-latency read mux for the single-cycle datapath
  always_comb begin
    rdata = '0;
    if (pread) begin
      case (addr)
        IO_STATUS: begin
          rdata[ST_LED_RDY] = led_ready;
          rdata[ST_SW_RDY]  = sw_ready;
        end
        IO_SWDATA: rdata = IO_DATA_W'(sw_data);
        IO_RESULT: rdata = IO_DATA_W'(calc_result);
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_port_ctrl
// Directed self-checking bench for io_port_ctrl with a 4-cycle debounce.
// Inputs change 1 time unit after a rising edge; the combinational read data
// is checked 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_io_port_ctrl;

  localparam int DEB   = 4;
  localparam int SW_W  = 16;
  localparam int RES_W = 12;

  localparam logic [1:0] A_STATUS = 2'b00;
  localparam logic [1:0] A_SWDATA = 2'b01;
  localparam logic [1:0] A_RESULT = 2'b10;
  localparam logic [1:0] A_RSVD   = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             pread;
  logic             pwrite;
  logic [1:0]       addr;
  logic [RES_W-1:0] wdata;
  logic [31:0]      rdata;
  logic             BTNL;
  logic             BTNR;
  logic [SW_W-1:0]  SW;
  logic [RES_W-1:0] calc_result;

  int assertCount = 0;
  int failCount   = 0;

  io_port_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_W           (SW_W),
    .RES_W          (RES_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pread      (pread),
    .pwrite     (pwrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .BTNL       (BTNL),
    .BTNR       (BTNR),
    .SW         (SW),
    .calc_result(calc_result)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle's worth of inputs
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [1:0] a, input logic [RES_W-1:0] d);
    pread  = rd;
    pwrite = wr;
    addr   = a;
    wdata  = d;
  endtask

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One read cycle: check rdata before the edge, the edge then commits it
  task automatic readReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, a, '0);
    #1;
    checkOutput(tag, rdata, expected);
    tick(1);
    applyStimulus(1'b0, 1'b0, 2'b00, '0);
  endtask

  // One write cycle
  task automatic writeReg(input logic [1:0] a, input logic [RES_W-1:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
    tick(1);
    applyStimulus(1'b0, 1'b0, 2'b00, '0);
  endtask

  initial begin
    $display("[TB] io_port_ctrl directed test, DEBOUNCE_CYCLES=%0d", DEB);
    reset = 1'b1;
    BTNL  = 1'b0;
    BTNR  = 1'b0;
    SW    = '0;
    applyStimulus(1'b0, 1'b0, 2'b00, '0);
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1. Reset state
    readReg("rst_status", A_STATUS, 32'h0);
    readReg("rst_swdata", A_SWDATA, 32'h0);
    checkOutput("rst_calc_result", 32'(calc_result), 32'h0);
    applyStimulus(1'b0, 1'b0, A_STATUS, '0);
    #1;
    checkOutput("rdata_no_pread", rdata, 32'h0);

    // 2. Held BTNR latches switches once
    SW   = 16'hA5C3;
    BTNR = 1'b1;
    tick(10);
    readReg("btnr_status", A_STATUS, 32'h2);
    readReg("btnr_swdata", A_SWDATA, 32'h0000A5C3);
    readReg("status_after_read", A_STATUS, 32'h0);
    tick(8);
    readReg("held_no_second_pulse", A_STATUS, 32'h0);
    BTNR = 1'b0;
    tick(10);
    readReg("release_no_pulse", A_STATUS, 32'h0);

    // 3. Bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      BTNR = ~BTNR;
      tick(2);
    end
    BTNR = 1'b0;
    tick(10);
    readReg("bounce_status", A_STATUS, 32'h0);

    // 4. RESULT write and BTNL handshake
    writeReg(A_RESULT, 12'h3E7);
    checkOutput("result_write", 32'(calc_result), 32'h3E7);
    readReg("result_read", A_RESULT, 32'h000003E7);
    BTNL = 1'b1;
    tick(10);
    readReg("btnl_status", A_STATUS, 32'h1);
    BTNL = 1'b0;
    tick(10);
    writeReg(A_RESULT, 12'h001);
    readReg("led_clear_status", A_STATUS, 32'h0);
    checkOutput("result_write2", 32'(calc_result), 32'h001);

    // 5a. btnr_p coincides with a SWDATA read (pulse is high 6 edges after press)
    SW   = 16'h1234;
    BTNR = 1'b1;
    tick(6);
    readReg("coinc_old_swdata", A_SWDATA, 32'h0000A5C3);
    readReg("coinc_sw_ready", A_STATUS, 32'h2);
    readReg("coinc_new_swdata", A_SWDATA, 32'h00001234);
    BTNR = 1'b0;
    tick(10);

    // 5b. btnl_p coincides with a RESULT write
    BTNL = 1'b1;
    tick(6);
    writeReg(A_RESULT, 12'h0AB);
    readReg("coinc_led_ready", A_STATUS, 32'h1);
    checkOutput("coinc_result", 32'(calc_result), 32'h0AB);
    BTNL = 1'b0;
    tick(10);

    // 6. Reset mid-debounce while BTNR held
    BTNR = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(15);
    readReg("held_thru_reset", A_STATUS, 32'h0);
    checkOutput("reset_calc_result", 32'(calc_result), 32'h0);
    BTNR = 1'b0;
    tick(10);
    readReg("release_after_reset", A_STATUS, 32'h0);
    SW   = 16'h00F0;
    BTNR = 1'b1;
    tick(10);
    readReg("repress_status", A_STATUS, 32'h2);
    BTNR = 1'b0;
    tick(10);
    writeReg(A_RSVD, 12'hFFF);
    checkOutput("rsvd_write_result", 32'(calc_result), 32'h0);
    readReg("rsvd_read", A_RSVD, 32'h0);
    readReg("rsvd_write_status", A_STATUS, 32'h2);
    readReg("repress_swdata", A_SWDATA, 32'h000000F0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
